// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier with valid/ready handshakes on both sides.
// Define MULT_SIGNED_EN to treat a, b and product as two's complement.
module seq_shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   // state | meaning
   // IDLE  | waiting for operands, in_ready high
   // CALC  | one partial product per clock, WIDTH clocks
   // DONE  | product presented, waiting for out_ready
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CNT_W = $clog2(WIDTH);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     acc_next;
   logic [WIDTH-1:0]     mplier_next;
   logic [2*WIDTH-1:0]   mag_next;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   result;

`ifdef MULT_SIGNED_EN
   logic sign_q, sign_d;

   // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned
   assign a_mag  = a[WIDTH-1] ? -a : a;
   assign b_mag  = b[WIDTH-1] ? -b : b;
   assign result = sign_q ? -mag_next : mag_next;
`else
   assign a_mag  = a;
   assign b_mag  = b;
   assign result = mag_next;
`endif

   // The adder carry lands in acc[WIDTH-1] after the shift, so no bit is lost
   assign sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_next    = sum[WIDTH:1];
   assign mplier_next = {sum[0], mplier_q[WIDTH-1:1]};
   assign mag_next    = {acc_next, mplier_next};

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;
`ifdef MULT_SIGNED_EN
      sign_d      = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               acc_d    = '0;
               cnt_d    = CNT_W'(WIDTH - 1);
`ifdef MULT_SIGNED_EN
               sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            acc_d    = acc_next;
            mplier_d = mplier_next;
            if (cnt_q == '0) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               product_d   = result;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
`ifdef MULT_SIGNED_EN
         sign_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
`ifdef MULT_SIGNED_EN
         sign_q      <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: a WIDTH=4 and a WIDTH=8 instance checked
// every cycle against a transaction-level model; honours MULT_SIGNED_EN.
module tb_seq_shift_add_multiplier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid4 = 1'b0, out_ready4 = 1'b1;
   logic       in_ready4, out_valid4, busy4;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] product4;

   logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
   logic        in_ready8, out_valid8, busy8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] product8;

   seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
      .product(product4), .busy(busy4)
   );

   seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .busy(busy8)
   );

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;
   int pcyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference product: plain integer multiply, reduced to 2*w bits
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] av, input logic [31:0] bv);
      longint pa, pb, p;
      logic [63:0] mask;
      pa = longint'(av);
      pb = longint'(bv);
`ifdef MULT_SIGNED_EN
      if (av[w-1]) pa = pa - (longint'(1) << w);
      if (bv[w-1]) pb = pb - (longint'(1) << w);
`endif
      p = pa * pb;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   // Transaction model: one job in flight, result due w+1 falling edges after the accept was seen
   bit          inf [2];
   int          rise[2];
   logic [63:0] expv[2];
   logic [63:0] last[2];

   task automatic check_dut(input int d, input int w, input logic iv, input logic ir,
                            input logic [31:0] av, input logic [31:0] bv,
                            input logic ov, input logic ordy, input logic bsy,
                            input logic [63:0] prod);
      bit ov_exp;
      if (!rst_n) begin
         inf[d]  = 1'b0;
         last[d] = '0;
         chk($sformatf("w%0d rst in_ready", w), 64'(ir), 64'd1);
         chk($sformatf("w%0d rst out_valid", w), 64'(ov), 64'd0);
         chk($sformatf("w%0d rst busy", w), 64'(bsy), 64'd0);
         chk($sformatf("w%0d rst product", w), prod, 64'd0);
         return;
      end
      ov_exp = inf[d] && (ncyc >= rise[d]);
      if (ov_exp) last[d] = expv[d];
      chk($sformatf("w%0d in_ready", w), 64'(ir), 64'(!inf[d]));
      chk($sformatf("w%0d busy", w), 64'(bsy), 64'(inf[d]));
      chk($sformatf("w%0d out_valid", w), 64'(ov), 64'(ov_exp));
      chk($sformatf("w%0d product", w), prod, last[d]);
      if (!inf[d]) begin
         if (iv) begin
            inf[d]  = 1'b1;
            rise[d] = ncyc + w + 1;
            expv[d] = ref_mul(w, av, bv);
         end
      end else if (ov_exp && ordy) begin
         inf[d] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      ncyc++;
      check_dut(0, 4, in_valid4, in_ready4, 32'(a4), 32'(b4), out_valid4, out_ready4, busy4, 64'(product4));
      check_dut(1, 8, in_valid8, in_ready8, 32'(a8), 32'(b8), out_valid8, out_ready8, busy8, 64'(product8));
   end

   always @(posedge clk) pcyc++;

   // Drive one WIDTH=4 transaction; hold>0 keeps out_ready low that many cycles in DONE
   task automatic run4(input logic [3:0] av, input logic [3:0] bv, input int hold,
                       output logic [7:0] prod);
      int k;
      int lat;
      @(posedge clk); #2;
      a4 = av; b4 = bv; in_valid4 = 1'b1; out_ready4 = (hold == 0);
      k = 0;
      while (!in_ready4 && k < 50) begin @(posedge clk); #2; k++; end
      chk("accept4 timeout", 64'(k < 50), 64'd1);
      @(posedge clk); #2;
      in_valid4 = 1'b0; a4 = ~av; b4 = ~bv;
      lat = 0;
      while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("latency4", 64'(lat), 64'd4);
      prod = product4;
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            in_valid4 = ~in_valid4; a4 = 4'($urandom); b4 = 4'($urandom);
            #1;
            chk("hold in_ready", 64'(in_ready4), 64'd0);
            chk("hold product", 64'(product4), 64'(prod));
         end
         in_valid4 = 1'b0; out_ready4 = 1'b1;
      end
      @(posedge clk); #1;
      chk("done exit out_valid", 64'(out_valid4), 64'd0);
      chk("done exit in_ready", 64'(in_ready4), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] p;
      logic [7:0] v;
      int k, t_prev;

      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 64'(in_ready4), 64'd1);
      chk("reset product", 64'(product4), 64'd0);
      #1 rst_n = 1'b1;

`ifndef MULT_SIGNED_EN
      run4(4'd15, 4'd15, 0, p); chk("15x15", 64'(p), 64'hE1);
      run4(4'd0, 4'd13, 0, p);  chk("0x13", 64'(p), 64'h00);
      run4(4'd9, 4'd0, 0, p);   chk("9x0", 64'(p), 64'h00);
      run4(4'd11, 4'd6, 5, p);  chk("11x6 held", 64'(p), 64'h42);
`else
      run4(4'h8, 4'h7, 0, p);   chk("-8x7", 64'(p), 64'hC8);
      run4(4'h8, 4'h8, 0, p);   chk("-8x-8", 64'(p), 64'h40);
      run4(4'h7, 4'hF, 0, p);   chk("7x-1", 64'(p), 64'hF9);
      run4(4'd11, 4'd6, 5, p);  chk("-5x6 held", 64'(p), 64'hE2);
`endif

      for (int i = 0; i < 256; i++) begin
         v = 8'(i);
         run4(v[7:4], v[3:0], 0, p);
      end

      // Reset two CALC edges into a job
      @(posedge clk); #2;
      a4 = 4'd7; b4 = 4'd5; in_valid4 = 1'b1;
      @(posedge clk); #2; in_valid4 = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 64'(out_valid4), 64'd0);
      chk("midrst busy", 64'(busy4), 64'd0);
      chk("midrst product", 64'(product4), 64'd0);
      @(posedge clk); #2; rst_n = 1'b1;
      run4(4'd3, 4'd4, 0, p); chk("3x4 after reset", 64'(p), 64'h0C);

      // Back-to-back on WIDTH=8 with both handshakes held high
      @(posedge clk); #2;
      out_ready8 = 1'b1; in_valid8 = 1'b1; t_prev = 0;
      for (int i = 0; i < 20; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         if (i == 0) begin a8 = 8'd200; b8 = 8'd250; end
         k = 0;
         while (!in_ready8 && k < 40) begin @(posedge clk); #2; k++; end
         chk("accept8 timeout", 64'(k < 40), 64'd1);
         @(posedge clk); #2;
         if (i > 0) chk("b2b gap", 64'(pcyc - t_prev), 64'd10);
         t_prev = pcyc;
      end
      in_valid8 = 1'b0;
      repeat (12) @(posedge clk);
      #1;
`ifndef MULT_SIGNED_EN
      chk("w8 idle product nonzero", 64'(product8 != ref_mul(8, 32'(a8), 32'(b8)) || product8 != 16'h0), 64'd1);
`endif
      chk("w8 drained", 64'(busy8), 64'd0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
